// File: rtl/vending_multi.sv
// vending_multi: multi-product vending controller with per-product stock,
// coin credit accumulation and valid/ready dispense and change outputs.
module vending_multi #(
   parameter int NUM_PRODUCTS = 4,
   parameter int CREDIT_W = 8,
   parameter int COIN_W = 4,
   parameter int MAX_CREDIT = 200,
   parameter int STOCK_W = 4,
   parameter int MAX_STOCK = 10,
   parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES = {8'd15, 8'd10, 8'd7, 8'd5}
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            coin_valid,
   input  logic [COIN_W-1:0]               coin_value,
   input  logic                            sel_valid,
   input  logic [$clog2(NUM_PRODUCTS)-1:0] sel_id,
   input  logic                            cancel,
   input  logic                            restock,
   output logic                            dispense_valid,
   output logic [$clog2(NUM_PRODUCTS)-1:0] dispense_id,
   input  logic                            dispense_ready,
   output logic                            change_valid,
   output logic [CREDIT_W-1:0]             change_amount,
   input  logic                            change_ready,
   output logic [CREDIT_W-1:0]             credit,
   output logic [NUM_PRODUCTS-1:0]         sold_out,
   output logic                            coin_reject,
   output logic                            sel_reject,
   output logic                            busy
);
   localparam logic [1:0] IDLE = 2'd0, CREDIT = 2'd1, VEND = 2'd2, CHANGE = 2'd3;
   logic [1:0] state;
   logic [STOCK_W-1:0] stock [NUM_PRODUCTS];
   logic [CREDIT_W:0] sum;
   logic [CREDIT_W-1:0] price;
   logic open_st, sel_ok, cancel_go, sel_go, coin_go;
   always_comb begin
      open_st = state == IDLE || state == CREDIT;
      sum = {1'b0, credit} + (CREDIT_W+1)'(coin_value);
      price = PRICES[sel_id*CREDIT_W +: CREDIT_W];
      sel_ok = state == CREDIT && 32'(sel_id) < NUM_PRODUCTS && stock[sel_id] != '0 && credit >= price;
      cancel_go = state == CREDIT && cancel;
      sel_go = sel_valid && sel_ok && !cancel_go;
      // a coin only lands when neither cancel nor a purchase claimed this cycle
      coin_go = coin_valid && open_st && !cancel_go && !sel_go && sum <= (CREDIT_W+1)'(MAX_CREDIT);
   end
   for (genvar i = 0; i < NUM_PRODUCTS; i++) begin : g_sold
      assign sold_out[i] = stock[i] == '0;
   end
   assign busy = state == VEND || state == CHANGE;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         credit <= '0;
         dispense_valid <= 1'b0;
         dispense_id <= '0;
         change_valid <= 1'b0;
         change_amount <= '0;
         coin_reject <= 1'b0;
         sel_reject <= 1'b0;
         for (int i = 0; i < NUM_PRODUCTS; i++) stock[i] <= STOCK_W'(MAX_STOCK);
      end else begin
         coin_reject <= coin_valid && !coin_go;
         sel_reject <= sel_valid && open_st && !cancel_go && !sel_ok;
         case (state)
            IDLE, CREDIT: begin
               if (cancel_go) begin
                  change_valid <= 1'b1;
                  change_amount <= credit;
                  state <= CHANGE;
               end else if (sel_go) begin
                  credit <= credit - price;
                  stock[sel_id] <= stock[sel_id] - STOCK_W'(1);
                  dispense_id <= sel_id;
                  dispense_valid <= 1'b1;
                  state <= VEND;
               end else if (coin_go) begin
                  credit <= sum[CREDIT_W-1:0];
                  state <= sum != '0 ? CREDIT : state;
               end
               if (state == IDLE && restock)
                  for (int i = 0; i < NUM_PRODUCTS; i++) stock[i] <= STOCK_W'(MAX_STOCK);
            end
            VEND: begin
               if (dispense_ready) begin
                  dispense_valid <= 1'b0;
                  change_valid <= credit != '0;
                  change_amount <= credit;
                  state <= credit != '0 ? CHANGE : IDLE;
               end
            end
            default: begin
               if (change_ready) begin
                  change_valid <= 1'b0;
                  credit <= '0;
                  state <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_vending_multi.sv
// tb_vending_multi: scenario tasks with a dispense/change scoreboard for vending_multi.
module tb_vending_multi;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic coin_valid = 1'b0;
   logic [3:0] coin_value = '0;
   logic sel_valid = 1'b0;
   logic [1:0] sel_id = '0;
   logic cancel = 1'b0;
   logic restock = 1'b0;
   logic dispense_valid;
   logic [1:0] dispense_id;
   logic dispense_ready = 1'b0;
   logic change_valid;
   logic [7:0] change_amount;
   logic change_ready = 1'b0;
   logic [7:0] credit;
   logic [3:0] sold_out;
   logic coin_reject, sel_reject, busy;
   int checks = 0;
   int errors = 0;
   int exp_disp[$];
   int exp_chg[$];
   int de, ce;
   int price[4] = '{5, 7, 10, 15};

   vending_multi dut (
      .clk(clk), .reset_n(reset_n), .coin_valid(coin_valid), .coin_value(coin_value),
      .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .restock(restock),
      .dispense_valid(dispense_valid), .dispense_id(dispense_id), .dispense_ready(dispense_ready),
      .change_valid(change_valid), .change_amount(change_amount), .change_ready(change_ready),
      .credit(credit), .sold_out(sold_out), .coin_reject(coin_reject), .sel_reject(sel_reject),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset_n && dispense_valid && dispense_ready) begin
         checks++;
         if (exp_disp.size() == 0) begin
            errors++;
            $display("FAIL disp_scoreboard: unexpected dispense id=%0d", dispense_id);
         end else begin
            de = exp_disp.pop_front();
            if (dispense_id !== 2'(de)) begin
               errors++;
               $display("FAIL disp_id: got %0d expected %0d", dispense_id, de);
            end
         end
      end
      if (reset_n && change_valid && change_ready) begin
         checks++;
         if (exp_chg.size() == 0) begin
            errors++;
            $display("FAIL chg_scoreboard: unexpected change amount=%0d", change_amount);
         end else begin
            ce = exp_chg.pop_front();
            if (change_amount !== 8'(ce)) begin
               errors++;
               $display("FAIL chg_amount: got %0d expected %0d", change_amount, ce);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic put_coin(input int v);
      coin_valid = 1'b1;
      coin_value = 4'(v);
      tick();
      coin_valid = 1'b0;
      coin_value = '0;
   endtask

   task automatic put_sel(input int id);
      sel_valid = 1'b1;
      sel_id = 2'(id);
      tick();
      sel_valid = 1'b0;
   endtask

   task automatic do_reset;
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic wait_not_busy(input string tag);
      int n = 0;
      while (busy && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL %s_timeout: busy still %0b after %0d cycles, expected 0", tag, busy, n);
      end
   endtask

   task automatic test_reset;
      do_reset();
      checks++;
      if ({dispense_valid, change_valid, coin_reject, sel_reject, busy} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 00000",
                  {dispense_valid, change_valid, coin_reject, sel_reject, busy});
      end
      checks++;
      if (credit !== 8'd0 || sold_out !== 4'b0 || dispense_id !== 2'd0 || change_amount !== 8'd0) begin
         errors++;
         $display("FAIL reset_values: credit=%0d sold_out=%b id=%0d chg=%0d expected all 0",
                  credit, sold_out, dispense_id, change_amount);
      end
   endtask

   task automatic test_idle_inputs;
      put_sel(0);
      checks++;
      if (sel_reject !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_sel: sel_reject=%b busy=%b expected 1 0", sel_reject, busy);
      end
      cancel = 1'b1;
      put_coin(0);
      cancel = 1'b0;
      checks++;
      if (credit !== 8'd0 || coin_reject !== 1'b0 || change_valid !== 1'b0 || sel_reject !== 1'b0) begin
         errors++;
         $display("FAIL idle_cancel_zero_coin: credit=%0d coin_rej=%b chg_v=%b sel_rej=%b expected 0 0 0 0",
                  credit, coin_reject, change_valid, sel_reject);
      end
   endtask

   task automatic test_exact_purchase;
      put_coin(2);
      put_coin(3);
      checks++;
      if (credit !== 8'd5) begin
         errors++;
         $display("FAIL exact_credit: got %0d expected 5", credit);
      end
      exp_disp.push_back(0);
      put_sel(0);
      checks++;
      if (dispense_valid !== 1'b1 || dispense_id !== 2'd0 || credit !== 8'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL exact_vend: dv=%b id=%0d credit=%0d busy=%b expected 1 0 0 1",
                  dispense_valid, dispense_id, credit, busy);
      end
      dispense_ready = 1'b1;
      tick();
      dispense_ready = 1'b0;
      checks++;
      if (dispense_valid !== 1'b0 || change_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL exact_done: dv=%b cv=%b busy=%b expected 0 0 0", dispense_valid, change_valid, busy);
      end
   endtask

   task automatic test_change_stall;
      put_coin(10);
      put_coin(5);
      exp_disp.push_back(1);
      exp_chg.push_back(15 - price[1]);
      put_sel(1);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (dispense_valid !== 1'b1 || dispense_id !== 2'd1 || change_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold%0d: dv=%b id=%0d cv=%b expected 1 1 0", i, dispense_valid, dispense_id, change_valid);
         end
      end
      dispense_ready = 1'b1;
      tick();
      dispense_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (change_valid !== 1'b1 || change_amount !== 8'(15 - price[1]) || dispense_valid !== 1'b0) begin
            errors++;
            $display("FAIL change_hold%0d: cv=%b amt=%0d dv=%b expected 1 %0d 0",
                     i, change_valid, change_amount, dispense_valid, 15 - price[1]);
         end
         if (i < 2) tick();
      end
      change_ready = 1'b1;
      tick();
      change_ready = 1'b0;
      checks++;
      if (change_valid !== 1'b0 || credit !== 8'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL change_done: cv=%b credit=%0d busy=%b expected 0 0 0", change_valid, credit, busy);
      end
   endtask

   task automatic test_insufficient_cancel;
      put_coin(5);
      put_sel(3);
      checks++;
      if (sel_reject !== 1'b1 || credit !== 8'd5 || dispense_valid !== 1'b0) begin
         errors++;
         $display("FAIL insuf_sel: sel_rej=%b credit=%0d dv=%b expected 1 5 0", sel_reject, credit, dispense_valid);
      end
      tick();
      checks++;
      if (sel_reject !== 1'b0) begin
         errors++;
         $display("FAIL insuf_pulse: sel_reject=%b expected 0", sel_reject);
      end
      exp_chg.push_back(5);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      checks++;
      if (change_valid !== 1'b1 || change_amount !== 8'd5 || busy !== 1'b1) begin
         errors++;
         $display("FAIL cancel_change: cv=%b amt=%0d busy=%b expected 1 5 1", change_valid, change_amount, busy);
      end
      change_ready = 1'b1;
      tick();
      change_ready = 1'b0;
      checks++;
      if (credit !== 8'd0 || change_valid !== 1'b0) begin
         errors++;
         $display("FAIL cancel_done: credit=%0d cv=%b expected 0 0", credit, change_valid);
      end
   endtask

   task automatic test_overflow;
      for (int i = 0; i < 13; i++) put_coin(15);
      checks++;
      if (credit !== 8'd195 || coin_reject !== 1'b0) begin
         errors++;
         $display("FAIL ovf_fill: credit=%0d coin_rej=%b expected 195 0", credit, coin_reject);
      end
      put_coin(15);
      checks++;
      if (coin_reject !== 1'b1 || credit !== 8'd195) begin
         errors++;
         $display("FAIL ovf_reject: coin_rej=%b credit=%0d expected 1 195", coin_reject, credit);
      end
      tick();
      checks++;
      if (coin_reject !== 1'b0) begin
         errors++;
         $display("FAIL ovf_pulse: coin_reject=%b expected 0", coin_reject);
      end
      put_coin(5);
      checks++;
      if (credit !== 8'd200 || coin_reject !== 1'b0) begin
         errors++;
         $display("FAIL ovf_ceiling: credit=%0d coin_rej=%b expected 200 0", credit, coin_reject);
      end
      exp_chg.push_back(200);
      change_ready = 1'b1;
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      wait_not_busy("ovf_refund");
      change_ready = 1'b0;
   endtask

   task automatic test_sold_out;
      do_reset();
      dispense_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         put_coin(price[0]);
         exp_disp.push_back(0);
         put_sel(0);
         wait_not_busy("sold_buy");
      end
      dispense_ready = 1'b0;
      checks++;
      if (sold_out !== 4'b0001) begin
         errors++;
         $display("FAIL sold_flag: got %b expected 0001", sold_out);
      end
      put_coin(5);
      put_sel(0);
      checks++;
      if (sel_reject !== 1'b1 || credit !== 8'd5 || dispense_valid !== 1'b0) begin
         errors++;
         $display("FAIL sold_sel: sel_rej=%b credit=%0d dv=%b expected 1 5 0", sel_reject, credit, dispense_valid);
      end
      restock = 1'b1;
      tick();
      restock = 1'b0;
      checks++;
      if (sold_out !== 4'b0001) begin
         errors++;
         $display("FAIL restock_credit: sold_out=%b expected 0001", sold_out);
      end
      exp_chg.push_back(5);
      change_ready = 1'b1;
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      wait_not_busy("sold_refund");
      change_ready = 1'b0;
      restock = 1'b1;
      tick();
      restock = 1'b0;
      checks++;
      if (sold_out !== 4'b0000) begin
         errors++;
         $display("FAIL restock_idle: sold_out=%b expected 0000", sold_out);
      end
   endtask

   task automatic test_collision_reset;
      put_coin(10);
      exp_disp.push_back(0);
      sel_valid = 1'b1;
      sel_id = 2'd0;
      coin_valid = 1'b1;
      coin_value = 4'd2;
      tick();
      sel_valid = 1'b0;
      coin_valid = 1'b0;
      checks++;
      if (dispense_valid !== 1'b1 || credit !== 8'(10 - price[0]) || coin_reject !== 1'b1 || sel_reject !== 1'b0) begin
         errors++;
         $display("FAIL collide_sel_coin: dv=%b credit=%0d coin_rej=%b sel_rej=%b expected 1 %0d 1 0",
                  dispense_valid, credit, coin_reject, sel_reject, 10 - price[0]);
      end
      sel_valid = 1'b1;
      sel_id = 2'd1;
      put_coin(3);
      sel_valid = 1'b0;
      checks++;
      if (coin_reject !== 1'b1 || sel_reject !== 1'b0 || credit !== 8'd5 || dispense_valid !== 1'b1 || dispense_id !== 2'd0) begin
         errors++;
         $display("FAIL vend_inputs: coin_rej=%b sel_rej=%b credit=%0d dv=%b id=%0d expected 1 0 5 1 0",
                  coin_reject, sel_reject, credit, dispense_valid, dispense_id);
      end
      dispense_ready = 1'b1;
      tick();
      dispense_ready = 1'b0;
      checks++;
      if (change_valid !== 1'b1 || change_amount !== 8'd5) begin
         errors++;
         $display("FAIL pre_reset_change: cv=%b amt=%0d expected 1 5", change_valid, change_amount);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (change_valid !== 1'b0 || credit !== 8'd0 || busy !== 1'b0 || dispense_valid !== 1'b0 || change_amount !== 8'd0) begin
         errors++;
         $display("FAIL async_reset: cv=%b credit=%0d busy=%b dv=%b amt=%0d expected 0 0 0 0 0",
                  change_valid, credit, busy, dispense_valid, change_amount);
      end
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_idle_inputs();
      test_exact_purchase();
      test_change_stall();
      test_insufficient_cancel();
      test_overflow();
      test_sold_out();
      test_collision_reset();
      tick();
      checks++;
      if (exp_disp.size() != 0 || exp_chg.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d dispense and %0d change left, expected 0 0",
                  exp_disp.size(), exp_chg.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
